// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC to imem, 2-entry fetch queue, valid/ready to decode, redirect flush
// Optional FETCH_BOUND_CHECK_EN: out-of-range fetch stores a NOP fault entry and halts until redirect/reset.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_fault
);

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic BOUND_CHECK = 1'b1;
`else
  localparam logic BOUND_CHECK = 1'b0;
`endif
  localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  logic [31:0] pc;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc [2];
  logic [1:0]  q_fault;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        halted;
  logic        pop;
  logic        push;
  logic        fault_now;

  assign if_valid  = (count != 2'd0);
  assign pop       = if_valid & id_ready;
  assign push      = !redirect_valid && ((count != 2'd2) || pop) && !halted;
  assign fault_now = BOUND_CHECK && (pc[31:2] >= DEPTH_WORDS);

  assign imem_addr = pc;

  // Gating on if_valid keeps the head fields at zero whenever the queue is empty.
  assign if_instr    = if_valid ? q_instr[rd_ptr] : 32'h0;
  assign if_pc       = if_valid ? q_pc[rd_ptr] : 32'h0;
  assign if_pc_plus4 = if_valid ? (q_pc[rd_ptr] + 32'd4) : 32'h0;
  assign if_fault    = if_valid & q_fault[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & 32'hFFFF_FFFC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
        if (fault_now) halted <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage needs no reset: nothing reads it until count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= fault_now ? NOP_INSTR : imem_rdata;
      q_pc[wr_ptr]    <= pc;
      q_fault[wr_ptr] <= fault_now;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench: queue-based fetch model plus directed literal checks
module tb_instruction_fetch_unit;

`ifdef FETCH_BOUND_CHECK_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1024;
`endif
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] WA  = 32'h0A0A_0A01;
  localparam logic [31:0] WB  = 32'h0B0B_0B02;
  localparam logic [31:0] WC  = 32'h0C0C_0C03;
  localparam logic [31:0] WD  = 32'h0D0D_0D04;
  localparam logic [31:0] W16 = 32'h4040_4016;
`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [31:0] TGT = 32'h0000_0013;
`else
  localparam logic [31:0] TGT = W16;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_fault;

  logic [31:0] mem [64];
  assign imem_rdata = mem[imem_addr[7:2]];

  instruction_fetch_unit #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_fault(if_fault)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a FIFO of fetched entries plus the next fetch address.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;
  entry_t      mq[$];
  logic [31:0] mpc = RPC;
  bit          mhalt = 1'b0;

  task automatic model_step();
    bit     do_pop;
    bit     room;
    bit     flt;
    entry_t e;
    if (rst) begin
      mq.delete();
      mpc   = RPC;
      mhalt = 1'b0;
      return;
    end
    do_pop = (mq.size() > 0) && id_ready;
    room   = (mq.size() < 2) || do_pop;
    if (do_pop) e = mq.pop_front();
    if (redirect_valid) begin
      mq.delete();
      mpc   = {redirect_pc[31:2], 2'b00};
      mhalt = 1'b0;
    end else if (room && !mhalt) begin
`ifdef FETCH_BOUND_CHECK_EN
      flt = (int'(mpc[31:2]) >= DEPTH);
`else
      flt = 1'b0;
`endif
      e.instr = flt ? 32'h0000_0013 : mem[mpc[7:2]];
      e.pc    = mpc;
      e.fault = flt;
      mq.push_back(e);
      mpc = mpc + 32'd4;
      if (flt) mhalt = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("m_valid", {31'b0, if_valid}, {31'b0, mq.size() > 0});
    chk("m_imem_addr", imem_addr, mpc);
    if (mq.size() > 0) begin
      chk("m_instr", if_instr, mq[0].instr);
      chk("m_pc", if_pc, mq[0].pc);
      chk("m_pc_plus4", if_pc_plus4, mq[0].pc + 32'd4);
      chk("m_fault", {31'b0, if_fault}, {31'b0, mq[0].fault});
    end
  end

  logic [31:0] xfer_pc[$];
  initial forever begin
    @(negedge clk);
    if (!rst && if_valid && id_ready) xfer_pc.push_back(if_pc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    id_ready = rdy;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] seq [4];
  int n4;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD; mem[16] = W16;
    seq[0] = WA; seq[1] = WB; seq[2] = WC; seq[3] = WD;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    #2 rst = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc_plus4, 32'd0);
    chk("rst_fault", {31'b0, if_fault}, 32'd0);
    chk("rst_imem_addr", imem_addr, RPC);

    // streaming A,B,C,D
    do_reset(1'b1);
    @(negedge clk);
    chk("t1_addr0", imem_addr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("t1_valid", {31'b0, if_valid}, 32'd1);
      chk("t1_instr", if_instr, seq[i]);
      chk("t1_pc", if_pc, 32'(4 * i));
      chk("t1_pc4", if_pc_plus4, 32'(4 * i + 4));
    end

    // decode stall for 5 cycles from the 2nd instruction
    do_reset(1'b1);
    step();
    step();
    id_ready = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("t2_hold_addr", imem_addr, 32'd12);
    chk("t2_hold_instr", if_instr, WB);
    step();
    id_ready = 1'b1;
    @(negedge clk);
    chk("t2_rel_b", if_instr, WB);
    step();
    @(negedge clk);
    chk("t2_rel_c", if_instr, WC);
    step();
    @(negedge clk);
    chk("t2_rel_d", if_instr, WD);

    // redirect with a full queue, unaligned target
    do_reset(1'b0);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_bubble_valid", {31'b0, if_valid}, 32'd0);
    chk("t3_bubble_addr", imem_addr, 32'h40);
    step();
    @(negedge clk);
    chk("t3_tgt_valid", {31'b0, if_valid}, 32'd1);
    chk("t3_tgt_pc", if_pc, 32'h40);
    chk("t3_tgt_instr", if_instr, TGT);

    // redirect in the same cycle as a pop
    do_reset(1'b1);
    xfer_pc.delete();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    chk("t4_head_pc", if_pc, 32'd4);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_bubble", {31'b0, if_valid}, 32'd0);
    step();
    @(negedge clk);
    #1;
    chk("t4_tgt_pc", if_pc, 32'h40);
    chk("t4_xfer_n", 32'(xfer_pc.size()), 32'd3);
    n4 = 0;
    foreach (xfer_pc[k]) if (xfer_pc[k] == 32'd4) n4++;
    chk("t4_head_once", 32'(n4), 32'd1);
    if (xfer_pc.size() == 3) chk("t4_xfer_last", xfer_pc[2], 32'h40);

`ifdef FETCH_BOUND_CHECK_EN
    // out-of-range fetch produces a fault entry then halts
    do_reset(1'b1);
    repeat (5) step();
    @(negedge clk);
    chk("t5_fault", {31'b0, if_fault}, 32'd1);
    chk("t5_nop", if_instr, 32'h13);
    chk("t5_pc", if_pc, 32'd16);
    step();
    step();
    @(negedge clk);
    chk("t5_halted", {31'b0, if_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    @(negedge clk);
    chk("t5_resume_instr", if_instr, WA);
    chk("t5_resume_fault", {31'b0, if_fault}, 32'd0);
`endif

    // asynchronous reset with a full queue
    do_reset(1'b0);
    step();
    step();
    @(negedge clk);
    chk("t6_full_valid", {31'b0, if_valid}, 32'd1);
    step();
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'b0, if_valid}, 32'd0);
    chk("t6_async_addr", imem_addr, RPC);
    step();
    rst = 1'b0;
    id_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t6_restart_pc", if_pc, RPC);
    chk("t6_restart_instr", if_instr, WA);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage for the single-core five-stage pipeline. Drives the program counter onto the instruction memory's word-addressed combinational read port, captures each returned instruction word into a two-entry fetch queue and presents it to decode over a valid/ready handshake. It absorbs decode stalls without dropping or re-fetching words, and it accepts branch/jump redirects that flush everything in flight.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; word-aligned.
- IMEM_DEPTH, 1024: instruction memory depth in 32-bit words; used only by the bound check.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; always equals the internal PC; bits [1:0] always 0.
- imem_rdata  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  input  1  branch/jump taken; flush and restart at redirect_pc.
- redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
- id_ready  input  1  decode can accept the head entry this cycle.
- if_valid  output  1  head entry valid.
- if_instr  output  32  head instruction word.
- if_pc  output  32  byte address of head instruction.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
- if_fault  output  1  head entry is a fetch fault (only with FETCH_BOUND_CHECK_EN); otherwise tied 0.

## Operation
- State: pc (32 b), queue of 2 entries {instr, pc, fault}, count (0..2), rd/wr pointers (1 b each, wrap 1->0).
- Reset, asynchronous: pc = RESET_PC, count = 0, pointers = 0, and if_valid = 0. if_instr, if_pc and if_pc_plus4 read 0, and if_fault = 0.
- pop = if_valid & id_ready. push = !redirect_valid & (count < 2 | pop) & !halted.
- On push: write {imem_rdata, pc, fault} at wr pointer, pc <= pc + 4 (wraps modulo 2^32), wr pointer advances.
- On pop: rd pointer advances. count updates by push - pop. Simultaneous push and pop at count 2 is legal, and count stays 2.
- Redirect has priority over all other activity. At the edge: count <= 0, pointers <= 0, pc <= {redirect_pc[31:2],2'b00}, and no push occurs.
- A pop handshake in the redirect cycle is still a valid transfer to decode; flushing does not retract it.
- No write to the queue ever occurs while count == 2 without a simultaneous pop; an overflow is a design error.
- Outputs are driven from the head entry; all if_* outputs are registered-state driven, with no combinational path from id_ready or imem_rdata.

## Timing
- Cycle after reset release: imem_addr = RESET_PC and push. if_valid = 1 from the next edge.
- Fetch-to-decode latency is 1 cycle. Sustained throughput is 1 instruction per cycle with id_ready held high.
- Decode stall (id_ready = 0): the queue fills to 2 within 2 cycles, then pc and imem_addr hold. When ready returns, the first pop and a refill happen in the same cycle, with no bubble.
- Redirect asserted in cycle N: imem_addr = target in N+1, and if_valid = 1 with if_pc = target from N+2. if_valid = 0 during N+1, which is exactly one bubble cycle.
- Back-to-back redirects: the last one wins, and each one restarts the 2-cycle latency.

## Configuration
- FETCH_BOUND_CHECK_EN defined:
  - A push with pc[31:2] >= IMEM_DEPTH stores an entry with fault = 1 and instr = 32'h0000_0013 (NOP), then sets halted.
  - While halted, no pushes occur and pc holds.
  - Only a redirect or reset clears halted.
  - if_fault mirrors the head entry's fault bit.
- Not defined: there is no check and no halted state. Out-of-range addresses are presented to memory unchanged, and if_fault is constant 0.

## Test plan
- Reset release with RESET_PC = 0 and id_ready = 1, memory words 0..3 = A,B,C,D -> if_instr sequence A,B,C,D on consecutive cycles, with if_pc = 0,4,8,12 and if_pc_plus4 = 4,8,12,16.
- id_ready low for 5 cycles starting at the 2nd instruction -> count saturates at 2 and imem_addr holds at 12. After release, B,C,D are delivered without a gap, duplicate, or loss.
- redirect_valid with redirect_pc = 32'h0000_0043 while the queue is full -> next cycle if_valid = 0 and imem_addr = 0x40; the following cycle if_pc = 0x40.
- Redirect and pop in the same cycle -> decode sees exactly one transfer of the head, then the bubble, then the target instruction.
- With FETCH_BOUND_CHECK_EN and IMEM_DEPTH = 4, sequential fetch from 0 -> the entry at pc 16 has if_fault = 1 and if_instr = 0x13, and fetch halts. A redirect to 0 resumes normal fetch.
- Assert rst mid-stream with a full queue -> if_valid drops immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
